// File: rtl/uart_word_tx_buffer_if.sv
// uart_word_tx_buffer_if: word request and UART byte start/done handshake bundle.
// The master side is the upstream/UART environment; the slave side is the buffer.
interface uart_word_tx_buffer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_start;
  logic                  i_tx_done;
  logic                  o_tx_start;
  logic [7:0]            o_tx_byte;
  logic                  o_empty;
  logic                  o_overflow;

  modport master (
    output i_data, i_start, i_tx_done,
    input  o_tx_start, o_tx_byte, o_empty, o_overflow
  );

  modport slave (
    input  i_data, i_start, i_tx_done,
    output o_tx_start, o_tx_byte, o_empty, o_overflow
  );
endinterface

// File: rtl/uart_word_tx_buffer.sv
// uart_word_tx_buffer: serialises one DATA_WIDTH word into MSB-first bytes over a start/done UART handshake.
// Define UART_WORD_TX_CHECKSUM_EN to append a running XOR checksum byte after each word.
module uart_word_tx_buffer #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic                  i_clk,
  input logic                  i_reset,
  uart_word_tx_buffer_if.slave bus_if
);
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned NB_BYTES = DATA_WIDTH / BYTE_W;
  localparam int unsigned CNT_W    = $clog2(NB_BYTES + 1);

`ifdef UART_WORD_TX_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE, CHECKSUM} state_e;
`else
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE} state_e;
`endif

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    tx_start_q, tx_start_d;
  logic [BYTE_W-1:0]       tx_byte_q, tx_byte_d;
  logic                    overflow_q, overflow_d;
  logic                    last_data_c;
`ifdef UART_WORD_TX_CHECKSUM_EN
  logic [BYTE_W-1:0]       csum_q, csum_d;
  logic                    csum_sent_c;
`endif

  assign last_data_c = (cnt_q == CNT_W'(NB_BYTES - 1));
`ifdef UART_WORD_TX_CHECKSUM_EN
  // Counter sits at NB_BYTES only while the checksum byte is in flight.
  assign csum_sent_c = (cnt_q == CNT_W'(NB_BYTES));
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus_if.i_start) state_d = LOAD;
      end
      LOAD: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus_if.i_tx_done) begin
`ifdef UART_WORD_TX_CHECKSUM_EN
          if (csum_sent_c)      state_d = IDLE;
          else if (last_data_c) state_d = CHECKSUM;
          else                  state_d = LOAD;
`else
          if (last_data_c) state_d = IDLE;
          else             state_d = LOAD;
`endif
        end
      end
`ifdef UART_WORD_TX_CHECKSUM_EN
      CHECKSUM: begin
        state_d = WAIT_DONE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    tx_start_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    overflow_d = overflow_q | (bus_if.i_start & (state_q != IDLE));
`ifdef UART_WORD_TX_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus_if.i_start) begin
          shift_d = bus_if.i_data;
          cnt_d   = '0;
`ifdef UART_WORD_TX_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      LOAD: begin
        tx_byte_d  = shift_q[DATA_WIDTH-1 -: BYTE_W];
        tx_start_d = 1'b1;
`ifdef UART_WORD_TX_CHECKSUM_EN
        csum_d     = csum_q ^ shift_q[DATA_WIDTH-1 -: BYTE_W];
`endif
      end
      WAIT_DONE: begin
`ifdef UART_WORD_TX_CHECKSUM_EN
        if (bus_if.i_tx_done && !csum_sent_c) begin
`else
        if (bus_if.i_tx_done) begin
`endif
          shift_d = shift_q << BYTE_W;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_WORD_TX_CHECKSUM_EN
      CHECKSUM: begin
        tx_byte_d  = csum_q;
        tx_start_d = 1'b1;
      end
`endif
      default: begin
        tx_start_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_byte_q  <= '0;
      overflow_q <= 1'b0;
`ifdef UART_WORD_TX_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tx_start_q <= tx_start_d;
      tx_byte_q  <= tx_byte_d;
      overflow_q <= overflow_d;
`ifdef UART_WORD_TX_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // o_empty falls in the same cycle as i_start so a registered upstream cannot double-issue.
  assign bus_if.o_empty    = (state_q == IDLE) && !bus_if.i_start;
  assign bus_if.o_tx_start = tx_start_q;
  assign bus_if.o_tx_byte  = tx_byte_q;
  assign bus_if.o_overflow = overflow_q;
endmodule

// File: tb/tb_uart_word_tx_buffer.sv
// tb_uart_word_tx_buffer: vector table, corner sequences and random words checked against a byte-stream model.
`timescale 1ns/1ps
module tb_uart_word_tx_buffer;
  localparam int unsigned DW = 32;
  localparam int unsigned NB = DW / 8;
`ifdef UART_WORD_TX_CHECKSUM_EN
  localparam int unsigned BPW = NB + 1;
`else
  localparam int unsigned BPW = NB;
`endif

  typedef struct {
    logic [31:0] data;
    int unsigned delay;
    logic [7:0]  exp_b [4];
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        resp_done = 1'b0;
  logic        force_done = 1'b0;
  logic        auto_done = 1'b1;
  int unsigned done_delay = 10;
  logic        prev_start = 1'b0;
  int          n_pass = 0;
  int          n_total = 0;
  logic [7:0]  got [$];
  logic [7:0]  exp_q [$];
  vec_t        vecs [5];

  uart_word_tx_buffer_if #(.DATA_WIDTH(DW)) bus ();

  uart_word_tx_buffer #(.DATA_WIDTH(DW)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus_if (bus)
  );

  assign bus.i_tx_done = resp_done | force_done;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Capture every byte handed to the UART and check the start pulse is one cycle wide.
  always @(negedge clk) begin
    if (bus.o_tx_start === 1'b1) begin
      got.push_back(bus.o_tx_byte);
      chk("tx_start_width", {31'd0, prev_start}, 32'd0);
    end
    prev_start = bus.o_tx_start;
  end

  // UART transmitter stand-in: one done tick done_delay cycles after each start.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.o_tx_start === 1'b1 && auto_done) begin
        bit aborted;
        aborted = 1'b0;
        for (int k = 0; k < int'(done_delay); k++) begin
          @(posedge clk);
          if (rst) aborted = 1'b1;
        end
        if (!aborted && !rst) begin
          #1 resp_done = 1'b1;
          @(posedge clk);
          #1 resp_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic [31:0] d, input int unsigned dl,
                              input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
    vec_t v;
    v.data = d;
    v.delay = dl;
    v.exp_b[0] = b0;
    v.exp_b[1] = b1;
    v.exp_b[2] = b2;
    v.exp_b[3] = b3;
    return v;
  endfunction

  // Reference: bytes of a word, MSB first, plus the XOR byte when the checksum is built in.
  function automatic void model_word(input logic [31:0] w);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < int'(NB); i++) begin
      exp_q.push_back(8'((w >> (8 * (int'(NB) - 1 - i))) & 32'hFF));
      x = x ^ 8'((w >> (8 * i)) & 32'hFF);
    end
`ifdef UART_WORD_TX_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    bus.i_start = 1'b0;
    force_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_start", {31'd0, bus.o_tx_start}, 32'd0);
    chk("rst_tx_byte", {24'd0, bus.o_tx_byte}, 32'd0);
    chk("rst_empty", {31'd0, bus.o_empty}, 32'd1);
    chk("rst_overflow", {31'd0, bus.o_overflow}, 32'd0);
  endtask

  task automatic send_start(input logic [31:0] w);
    @(posedge clk);
    #1 bus.i_data = w;
    bus.i_start = 1'b1;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    bus.i_data = $urandom();
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int c;
    c = 0;
    while (got.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (got.size() < n) chk("timeout_bytes", 32'(got.size()), 32'(n));
  endtask

  task automatic compare_stream(input string tag);
    chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) chk($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]}, {24'd0, exp_q[i]});
    end
    got.delete();
    exp_q.delete();
  endtask

  // Wait for the last byte's done tick; o_empty must rise the following cycle.
  task automatic finish_word(input string tag);
    int c;
    c = 0;
    wait_bytes(exp_q.size(), 2000);
    while (bus.i_tx_done !== 1'b1 && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (c >= 200) begin
      chk({tag, "_timeout_done"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_busy_at_last_done"}, {31'd0, bus.o_empty}, 32'd0);
      @(negedge clk);
      chk({tag, "_empty_after_done"}, {31'd0, bus.o_empty}, 32'd1);
    end
    compare_stream(tag);
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_data = '0;

    vecs[0] = mk(32'h636F6E74, 10, 8'h63, 8'h6F, 8'h6E, 8'h74);
    vecs[1] = mk(32'hFFFFFFFF, 3, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    vecs[2] = mk(32'h11223344, 1, 8'h11, 8'h22, 8'h33, 8'h44);
    vecs[3] = mk(32'h00000001, 7, 8'h00, 8'h00, 8'h00, 8'h01);
    vecs[4] = mk(32'h80000000, 2, 8'h80, 8'h00, 8'h00, 8'h00);

    do_reset();

    // Table-driven words.
    for (int i = 0; i < 5; i++) begin
      logic [7:0] x;
      x = 8'h00;
      done_delay = vecs[i].delay;
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(vecs[i].exp_b[b]);
        x = x ^ vecs[i].exp_b[b];
      end
`ifdef UART_WORD_TX_CHECKSUM_EN
      exp_q.push_back(x);
`endif
      send_start(vecs[i].data);
      finish_word($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_overflow", i), {31'd0, bus.o_overflow}, 32'd0);
    end

    // Registered upstream issuing back-to-back words as soon as o_empty is seen.
    done_delay = 2;
    for (int w = 1; w <= 3; w++) begin
      int c;
      c = 0;
      @(negedge clk);
      while (bus.o_empty !== 1'b1 && c < 500) begin
        @(negedge clk);
        c++;
      end
      if (c >= 500) chk("b2b_timeout_empty", 32'd0, 32'd1);
      model_word(32'(w));
      send_start(32'(w));
    end
    finish_word("b2b");
    chk("b2b_overflow", {31'd0, bus.o_overflow}, 32'd0);

    // Stray done tick while idle must not shorten the next word.
    @(posedge clk);
    #1 force_done = 1'b1;
    @(posedge clk);
    #1 force_done = 1'b0;
    done_delay = 4;
    model_word(32'h11223344);
    send_start(32'h11223344);
    finish_word("stray_done");

    // Start request during WAIT_DONE of byte 2 is dropped and flagged.
    done_delay = 10;
    model_word(32'h55667788);
    send_start(32'h55667788);
    wait_bytes(2, 500);
    repeat (3) @(negedge clk);
    send_start(32'hDEADBEEF);
    @(negedge clk);
    chk("ovf_set", {31'd0, bus.o_overflow}, 32'd1);
    finish_word("ovf_word");
    done_delay = 3;
    model_word(32'h01020304);
    send_start(32'h01020304);
    finish_word("ovf_next");
    chk("ovf_sticky", {31'd0, bus.o_overflow}, 32'd1);
    do_reset();

    // Start in the same cycle as the final done tick is an overflow.
    auto_done = 1'b0;
    model_word(32'h0A0B0C0D);
    send_start(32'h0A0B0C0D);
    for (int b = 0; b < int'(BPW); b++) begin
      wait_bytes(b + 1, 500);
      repeat (3) @(posedge clk);
      #1 force_done = 1'b1;
      if (b == int'(BPW) - 1) begin
        bus.i_start = 1'b1;
        bus.i_data = 32'hDEADBEEF;
      end
      @(posedge clk);
      #1 force_done = 1'b0;
      bus.i_start = 1'b0;
    end
    @(negedge clk);
    chk("same_cycle_empty", {31'd0, bus.o_empty}, 32'd1);
    chk("same_cycle_overflow", {31'd0, bus.o_overflow}, 32'd1);
    repeat (20) @(negedge clk);
    compare_stream("same_cycle");
    auto_done = 1'b1;
    do_reset();

    // Reset between bytes 2 and 3 discards the rest of the word.
    done_delay = 10;
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hB2);
    send_start(32'hA1B2C3D4);
    wait_bytes(2, 500);
    repeat (3) @(negedge clk);
    do_reset();
    repeat (30) @(negedge clk);
    compare_stream("rst_abort");
    chk("rst_abort_start_low", {31'd0, bus.o_tx_start}, 32'd0);
    model_word(32'h0000000A);
    send_start(32'h0000000A);
    finish_word("after_abort");

    // Random words with random UART latency and idle gaps.
    for (int i = 0; i < 25; i++) begin
      logic [31:0] w;
      w = $urandom();
      done_delay = $urandom_range(1, 12);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      model_word(w);
      send_start(w);
      finish_word($sformatf("rand%0d", i));
    end
    chk("rand_overflow", {31'd0, bus.o_overflow}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
